// File: rtl/wb_drain.sv
// Write-buffer drain: pops {strb, addr, data} entries from the write FIFO and issues each as one
// PicoRV32-native bus write. Optional bus-ready timeout enabled by defining WB_DRAIN_TIMEOUT_EN.
module wb_drain #(
    parameter int unsigned W_ADDR         = 32,
    parameter int unsigned W_DATA         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    localparam int unsigned W_STRB        = W_DATA / 8,
    localparam int unsigned W_ENTRY       = W_STRB + W_ADDR + W_DATA
) (
    input  logic               sClk_i,
    input  logic               snRst_i,
    input  logic               Empty_i,
    input  logic [W_ENTRY-1:0] ReadData_i,
    output logic               Read_o,
    input  logic               Stall_i,
    output logic               mem_valid_o,
    output logic [W_ADDR-1:0]  mem_addr_o,
    output logic [W_DATA-1:0]  mem_wdata_o,
    output logic [W_STRB-1:0]  mem_wstrb_o,
    input  logic               mem_ready_i,
    output logic               Idle_o,
    output logic [15:0]        DrainCount_o,
    output logic               Error_o,
    input  logic               ErrClr_i
);

    typedef enum logic {IDLE, REQ} state_t;

    state_t state, state_nxt;
    logic   handshake;
    logic   take;
    logic   timeout;

    assign handshake = (state == REQ) & mem_ready_i;
    assign take      = ~Empty_i & ~Stall_i & ((state == IDLE) | handshake) & ~timeout;

    always_ff @(posedge sClk_i or negedge snRst_i) begin
        if (!snRst_i) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (take)                        state_nxt = REQ;
        else if (handshake || timeout)   state_nxt = IDLE;
    end

    always_comb begin
        mem_valid_o = (state == REQ);
        Idle_o      = (state == IDLE) & Empty_i;
        Read_o      = take;
    end

    always_ff @(posedge sClk_i or negedge snRst_i) begin
        if (!snRst_i) begin
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_wstrb_o <= '0;
        end else if (take) begin
            mem_wstrb_o <= ReadData_i[W_ENTRY-1 -: W_STRB];
            mem_addr_o  <= ReadData_i[W_ADDR+W_DATA-1 -: W_ADDR];
            mem_wdata_o <= ReadData_i[W_DATA-1:0];
        end
    end

    always_ff @(posedge sClk_i or negedge snRst_i) begin
        if (!snRst_i)       DrainCount_o <= '0;
        else if (handshake) DrainCount_o <= DrainCount_o + 16'd1;
    end

`ifdef WB_DRAIN_TIMEOUT_EN
    localparam int unsigned W_WAIT = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [W_WAIT-1:0] wait_cnt;

    // wait_cnt holds the number of earlier no-ready cycles of the current transfer
    assign timeout = (state == REQ) & ~mem_ready_i
                   & (wait_cnt == W_WAIT'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge sClk_i or negedge snRst_i) begin
        if (!snRst_i)                          wait_cnt <= '0;
        else if (take || handshake || timeout) wait_cnt <= '0;
        else if (state == REQ)                 wait_cnt <= wait_cnt + 1'b1;
    end

    always_ff @(posedge sClk_i or negedge snRst_i) begin
        if (!snRst_i)      Error_o <= 1'b0;
        else if (timeout)  Error_o <= 1'b1;
        else if (ErrClr_i) Error_o <= 1'b0;
    end
`else
    logic unused_errclr;

    assign timeout       = 1'b0;
    assign Error_o       = 1'b0;
    assign unused_errclr = ErrClr_i;
`endif

endmodule

// File: tb/tb_wb_drain.sv
// Directed bench for wb_drain: a queue-based FIFO plus a transaction-level model of the drain,
// compared against the DUT on every falling edge, with literal checks at key points.
module tb_wb_drain;
    localparam int TO = 4;
    localparam int WE = 68;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          empty = 1'b1;
    logic [WE-1:0] rdata = '0;
    logic          read;
    logic          stall = 1'b0;
    logic          valid;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          ready = 1'b0;
    logic          idle;
    logic [15:0]   count;
    logic          err;
    logic          errclr = 1'b0;

    wb_drain #(.W_ADDR(32), .W_DATA(32), .TIMEOUT_CYCLES(TO)) dut (
        .sClk_i(clk), .snRst_i(rst_n), .Empty_i(empty), .ReadData_i(rdata), .Read_o(read),
        .Stall_i(stall), .mem_valid_o(valid), .mem_addr_o(addr), .mem_wdata_o(wdata),
        .mem_wstrb_o(wstrb), .mem_ready_i(ready), .Idle_o(idle), .DrainCount_o(count),
        .Error_o(err), .ErrClr_i(errclr)
    );

    always #5 clk = ~clk;

    logic [WE-1:0] q[$];
    bit            m_busy = 1'b0;
    logic [WE-1:0] m_cur = '0;
    logic [15:0]   m_cnt = '0;
    bit            m_err = 1'b0;
    int unsigned   m_wait = 0;

    int total = 0;
    int bad = 0;
    int n_reads = 0;
    int cyc = 0;
    logic [31:0] hs_addr[$];
    int          hs_cyc[$];

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", n, a, e, $time);
        end
    endtask

    function automatic logic [WE-1:0] mk(input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
        return {s, a, d};
    endfunction

    task automatic refresh();
        empty = (q.size() == 0);
        rdata = (q.size() != 0) ? q[0] : '0;
    endtask

    task automatic push(input logic [WE-1:0] e);
        q.push_back(e);
        refresh();
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic bit m_timeout();
`ifdef WB_DRAIN_TIMEOUT_EN
        return m_busy && !ready && (m_wait == TO - 1);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_take();
        return (q.size() != 0) && !stall && (!m_busy || ready) && !m_timeout();
    endfunction

    // Transaction model: a write is outstanding from capture until the slave accepts it.
    always @(posedge clk or negedge rst_n) begin
        bit tk, to, hs;
        if (!rst_n) begin
            m_busy = 1'b0; m_cur = '0; m_cnt = '0; m_err = 1'b0; m_wait = 0;
        end else begin
            tk = m_take();
            to = m_timeout();
            hs = m_busy && ready;
            if (hs) m_cnt = m_cnt + 16'd1;
            if (to) m_err = 1'b1;
            else if (errclr) m_err = 1'b0;
            if (tk) begin
                m_cur  = q.pop_front();
                m_busy = 1'b1;
                m_wait = 0;
            end else if (hs || to) begin
                m_busy = 1'b0;
                m_wait = 0;
            end else if (m_busy) begin
                m_wait++;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        refresh();
    end

    always @(negedge clk) begin
        cyc++;
        chk("read", read, m_take());
        chk("valid", valid, m_busy);
        if (m_busy) begin
            chk("strb", wstrb, m_cur[67:64]);
            chk("addr", addr, m_cur[63:32]);
            chk("wdata", wdata, m_cur[31:0]);
        end
        chk("idle", idle, !m_busy && (q.size() == 0));
        chk("count", count, m_cnt);
        chk("error", err, m_err);
        if (read) n_reads++;
        if (valid && ready) begin
            hs_addr.push_back(addr);
            hs_cyc.push_back(cyc);
        end
    end

    initial begin
        int r0;
        int guard;

        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk("rst_valid", valid, 1'b0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_count", count, 16'h0);
        chk("rst_idle", idle, 1'b1);

        // single entry, ready on the second valid cycle
        push(mk(4'hF, 32'h0000_1000, 32'hDEAD_BEEF));
        tick(1);
        chk("single_addr", addr, 32'h0000_1000);
        chk("single_data", wdata, 32'hDEAD_BEEF);
        chk("single_strb", wstrb, 4'hF);
        tick(1);
        chk("single_hold", addr, 32'h0000_1000);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        tick(1);
        chk("single_reads", n_reads, 1);
        chk("single_count", count, 16'd1);
        chk("single_idle", idle, 1'b1);

        // streaming: 8 preloaded entries, ready tied high
        stall = 1'b1;
        for (int i = 0; i < 8; i++) push(mk(4'h1 << (i % 4), 32'h2000 + 32'(i) * 4, 32'hA000 + 32'(i)));
        hs_addr.delete();
        hs_cyc.delete();
        tick(1);
        stall = 1'b0;
        ready = 1'b1;
        tick(11);
        ready = 1'b0;
        chk("stream_n", hs_addr.size(), 8);
        if (hs_addr.size() == 8) begin
            for (int i = 0; i < 8; i++) chk("stream_order", hs_addr[i], 32'h2000 + 32'(i) * 4);
            chk("stream_nogap", hs_cyc[7] - hs_cyc[0], 7);
        end
        chk("stream_count", count, 16'd9);

        // backpressure: ready low for 5 cycles
        push(mk(4'h3, 32'h3000, 32'h1111_2222));
        push(mk(4'hC, 32'h3004, 32'h3333_4444));
        tick(1);
        r0 = n_reads;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("bp_addr", addr, 32'h3000);
            chk("bp_data", wdata, 32'h1111_2222);
            chk("bp_valid", valid, 1'b1);
        end
        chk("bp_reads", n_reads, r0);
        chk("bp_level", q.size(), 1);
        ready = 1'b1;
        tick(3);
        ready = 1'b0;
        chk("bp_count", count, 16'd11);

        // stall with 3 queued: current completes, no further pops until release
        for (int i = 0; i < 3; i++) push(mk(4'hF, 32'h4000 + 32'(i) * 4, 32'h5500 + 32'(i)));
        tick(1);
        stall = 1'b1;
        ready = 1'b1;
        r0 = n_reads;
        tick(4);
        chk("stall_reads", n_reads, r0);
        chk("stall_valid", valid, 1'b0);
        chk("stall_count", count, 16'd12);
        stall = 1'b0;
        tick(4);
        ready = 1'b0;
        chk("stall_drain", count, 16'd14);
        chk("stall_idle", idle, 1'b1);

`ifdef WB_DRAIN_TIMEOUT_EN
        push(mk(4'hF, 32'h6000, 32'h6666_6666));
        tick(5);
        chk("to_valid", valid, 1'b0);
        chk("to_err", err, 1'b1);
        chk("to_count", count, 16'd14);
        errclr = 1'b1;
        tick(1);
        errclr = 1'b0;
        chk("to_clr", err, 1'b0);
`else
        errclr = 1'b1;
        tick(1);
        errclr = 1'b0;
        chk("no_err", err, 1'b0);
`endif

        // reset in the middle of a transfer
        push(mk(4'h5, 32'h7000, 32'h7777_0000));
        push(mk(4'hA, 32'h7004, 32'h7777_0004));
        tick(2);
        stall = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_valid", valid, 1'b0);
        chk("mrst_addr", addr, 32'h0);
        chk("mrst_count", count, 16'h0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        stall = 1'b0;
        ready = 1'b1;
        hs_addr.delete();
        tick(3);
        chk("mrst_next", (hs_addr.size() != 0) ? hs_addr[0] : 32'hFFFF_FFFF, 32'h7004);
        chk("mrst_count2", count, 16'd1);

        // run the counter to 0xFFFF, then across the wrap
        guard = 0;
        while (m_cnt != 16'hFFFF && guard < 70000) begin
            if (q.size() < 2) push(mk(4'h3, 32'(guard) * 4, 32'(guard)));
            tick(1);
            guard++;
        end
        chk("wrap_max", count, 16'hFFFF);
        tick(1);
        chk("wrap_zero", count, 16'h0);
        tick(4);
        ready = 1'b0;
        chk("end_idle", idle, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_drain.md
# wb_drain

Write-buffer drain engine for the cache subsystem: sits directly downstream of the shift-register write FIFO, pops packed `{strb, addr, data}` entries from it and issues each as a single write on the PicoRV32-native memory bus. Holds at most one transfer in flight and supports back-to-back issue, so a continuously non-empty FIFO drains at one word per cycle against a zero-wait slave.

## Interface
- `W_ADDR`, 32, address width.
- `W_DATA`, 32, data width; strobe width `W_STRB = W_DATA/8`.
- `TIMEOUT_CYCLES`, 256, bus-ready timeout; used only with `WB_DRAIN_TIMEOUT_EN`; must be ≥ 2.
- Entry width `W_ENTRY = W_STRB+W_ADDR+W_DATA`, packed MSB→LSB as strb, addr, data.

- `sClk_i`  in  1  clock, rising edge.
- `snRst_i`  in  1  reset, asynchronous, active-low.
- `Empty_i`  in  1  FIFO empty flag.
- `ReadData_i`  in  W_ENTRY  FIFO head entry; valid while `Empty_i` = 0.
- `Read_o`  out  1  FIFO pop, combinational, one pulse per entry taken.
- `Stall_i`  in  1  blocks new pops; does not affect a transfer already on the bus.
- `mem_valid_o`  out  1  bus request, registered.
- `mem_addr_o`  out  W_ADDR  registered write address.
- `mem_wdata_o`  out  W_DATA  registered write data.
- `mem_wstrb_o`  out  W_STRB  registered byte strobes.
- `mem_ready_i`  in  1  slave accept.
- `Idle_o`  out  1  state IDLE and `Empty_i` = 1.
- `DrainCount_o`  out  16  completed-write counter; wraps 0xFFFF→0.
- `Error_o`  out  1  sticky timeout flag.
- `ErrClr_i`  in  1  clears `Error_o`.

## Operation
- States: IDLE, REQ.
- `Take` = `~Empty_i & ~Stall_i & (IDLE | (REQ & mem_ready_i))`, and no timeout abort this cycle. `Read_o` = `Take`.
- On `Take`, capture `ReadData_i` into the addr/data/strb registers and enter (or remain in) REQ; `mem_valid_o` = 1 from the next cycle.
- REQ & `mem_ready_i` & ~`Take`: drop `mem_valid_o` and go to IDLE.
- Every cycle with `mem_valid_o & mem_ready_i`, `DrainCount_o` increments by 1 (modulo 2^16).
- While in REQ without `mem_ready_i`, addr/data/strb stay stable and `mem_valid_o` stays 1.
- `mem_ready_i` is ignored while `mem_valid_o` = 0.
- `Stall_i` in REQ only prevents chaining. The current transfer still completes, then the block returns to IDLE.
- `ErrClr_i` clears `Error_o` the next cycle; a simultaneous timeout wins, so `Error_o` stays 1.

## Timing
- Reset values (asynchronous): state IDLE, `mem_valid_o`=0, `mem_addr_o`/`mem_wdata_o`/`mem_wstrb_o`=0, `DrainCount_o`=0, `Error_o`=0. `Read_o` follows its combinational equation, so it is 0 while the FIFO is empty.
- Latency: `Empty_i` falls at cycle t in IDLE → `Read_o`=1 at t → `mem_valid_o`=1 at t+1.
- Back-to-back: ready at cycle n with FIFO non-empty → pop at n, new entry on bus at n+1, `mem_valid_o` never drops.
- Reset mid-transfer: bus request withdrawn immediately. A popped but uncompleted entry is lost, which is accepted behaviour.
- Simultaneous last pop and FIFO write: the block only sees `Empty_i`/`ReadData_i`, so no special case is needed.

## Configuration
- `WB_DRAIN_TIMEOUT_EN` defined: a cycle counter runs in REQ, is cleared on every handshake or new capture, and reaches `TIMEOUT_CYCLES` consecutive cycles without `mem_ready_i`. At that point the block forces IDLE, drops `mem_valid_o`, sets `Error_o`, does not count the write, and suppresses `Take` in that cycle.
- Undefined: no counter, REQ waits indefinitely, `Error_o` tied 0, `ErrClr_i` unused.

## Test plan
- Single entry: push `{4'hF, 32'h0000_1000, 32'hDEAD_BEEF}`, ready at 2nd cycle of valid → one `Read_o` pulse, bus shows the exact addr/data/strb for 2 cycles, `DrainCount_o`=1, `Idle_o`=1 after.
- Streaming: 8 entries preloaded, `mem_ready_i` tied 1 → 8 consecutive `mem_valid_o` cycles with no gap, addresses in push order, `DrainCount_o`=8.
- Backpressure: ready held low for 5 cycles → addr/data stable, no extra `Read_o`, FIFO level unchanged.
- Stall: `Stall_i`=1 with 3 entries queued → current write completes, then no pops; release → remaining 2 drain.
- Timeout (`WB_DRAIN_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4): ready never asserted → `mem_valid_o` drops after 4 cycles, `Error_o`=1, `DrainCount_o` unchanged; `ErrClr_i` pulse → 0.
- Reset assertion mid-REQ → all outputs 0 asynchronously; after release, next FIFO entry drains normally; counter wraps from 0xFFFF to 0.
